// File: rtl/irda_fir_flag_det.sv
// IrDA FIR (4PPM) flag detector: tracks PA preamble, STA and STO flags on a
// 32-chip sliding window and decodes data symbols between STA and STO.
module irda_fir_flag_det #(
  parameter int unsigned PA_MIN = 4
) (
  input  logic       clk,
  input  logic       wb_rst_n,
  input  logic       fir_rx8_enable,
  input  logic       rx_chip,
  input  logic       det_enable,
  output logic       pa_det,
  output logic [3:0] pa_count,
  output logic       sta_det,
  output logic       sto_det,
  output logic       frame_active,
  output logic       sym_valid,
  output logic [1:0] sym_data,
  output logic       sym_err
);

  localparam logic [15:0] PA_PAT   = 16'h80A8;
  localparam logic [31:0] STA_PAT  = 32'h0C0C_6060;
  localparam logic [31:0] STO_PAT  = 32'h0C0C_0606;
  localparam logic [3:0]  PA_MIN_C = 4'(PA_MIN);

  typedef enum logic [1:0] {HUNT, PREAMBLE, FRAME} state_e;

  state_e      state_q, state_d;
  logic [31:0] window_q, window_d;
  logic [5:0]  fill_q, fill_d;       // chips seen since reset, saturating at 32
  logic [5:0]  gap_q, gap_d;
  logic [4:0]  sym_cnt_q, sym_cnt_d;
  logic [3:0]  pa_count_q, pa_count_d;
  logic        frame_active_q, frame_active_d;
  logic        pa_det_q, pa_det_d;
  logic        sta_det_q, sta_det_d;
  logic        sto_det_q, sto_det_d;
  logic        sym_valid_q, sym_valid_d;
  logic [1:0]  sym_data_q, sym_data_d;
  logic        sym_err_q, sym_err_d;

  logic        pa_hit, sta_hit, sto_hit;
  logic [1:0]  dec_data;
  logic        dec_err;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (fir_rx8_enable) begin
      window_d = {window_q[30:0], rx_chip};
      if (fill_q != 6'd32) fill_d = fill_q + 6'd1;
    end
  end

  // Flags are judged on the window as it stands after this strobe's chip.
  assign pa_hit  = fir_rx8_enable && (fill_d >= 6'd16) && (window_d[15:0] == PA_PAT);
  assign sta_hit = fir_rx8_enable && (fill_d == 6'd32) && (window_d == STA_PAT);
  assign sto_hit = fir_rx8_enable && (fill_d == 6'd32) && (window_d == STO_PAT);

  always_comb begin
    dec_data = 2'b00;
    dec_err  = 1'b0;
    case (window_d[31:28])
      4'b1000: dec_data = 2'b00;
      4'b0100: dec_data = 2'b01;
      4'b0010: dec_data = 2'b10;
      4'b0001: dec_data = 2'b11;
      default: dec_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    gap_d          = gap_q;
    sym_cnt_d      = sym_cnt_q;
    pa_count_d     = pa_count_q;
    frame_active_d = frame_active_q;
    pa_det_d       = 1'b0;
    sta_det_d      = 1'b0;
    sto_det_d      = 1'b0;
    sym_valid_d    = 1'b0;
    sym_data_d     = 2'b00;
    sym_err_d      = 1'b0;

    if (!det_enable) begin
      state_d        = HUNT;
      gap_d          = '0;
      sym_cnt_d      = '0;
      pa_count_d     = '0;
      frame_active_d = 1'b0;
    end else if (fir_rx8_enable) begin
      case (state_q)
        HUNT: begin
          if (pa_hit) begin
            state_d    = PREAMBLE;
            pa_count_d = 4'd1;
            pa_det_d   = 1'b1;
            gap_d      = '0;
          end
        end
        PREAMBLE: begin
          if (sta_hit && (pa_count_q >= PA_MIN_C)) begin
            state_d        = FRAME;
            sta_det_d      = 1'b1;
            frame_active_d = 1'b1;
            pa_count_d     = '0;
            sym_cnt_d      = '0;
            gap_d          = '0;
          end else if (pa_hit) begin
            pa_det_d = 1'b1;
            gap_d    = '0;
            if (pa_count_q != 4'd15) pa_count_d = pa_count_q + 4'd1;
          end else if (gap_q == 6'd32) begin
            state_d    = HUNT;
            pa_count_d = '0;
            gap_d      = '0;
          end else begin
            gap_d = gap_q + 6'd1;
          end
        end
        FRAME: begin
          if (sto_hit) begin
            state_d        = HUNT;
            sto_det_d      = 1'b1;
            frame_active_d = 1'b0;
            sym_cnt_d      = '0;
          end else if (sym_cnt_q == 5'd31) begin
            // Symbols lag 32 chips so a trailing STO is never emitted as data.
            sym_valid_d = 1'b1;
            sym_data_d  = dec_data;
            sym_err_d   = dec_err;
            sym_cnt_d   = 5'd28;
          end else begin
            sym_cnt_d = sym_cnt_q + 5'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q        <= HUNT;
      window_q       <= '0;
      fill_q         <= '0;
      gap_q          <= '0;
      sym_cnt_q      <= '0;
      pa_count_q     <= '0;
      frame_active_q <= 1'b0;
      pa_det_q       <= 1'b0;
      sta_det_q      <= 1'b0;
      sto_det_q      <= 1'b0;
      sym_valid_q    <= 1'b0;
      sym_data_q     <= 2'b00;
      sym_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      window_q       <= window_d;
      fill_q         <= fill_d;
      gap_q          <= gap_d;
      sym_cnt_q      <= sym_cnt_d;
      pa_count_q     <= pa_count_d;
      frame_active_q <= frame_active_d;
      pa_det_q       <= pa_det_d;
      sta_det_q      <= sta_det_d;
      sto_det_q      <= sto_det_d;
      sym_valid_q    <= sym_valid_d;
      sym_data_q     <= sym_data_d;
      sym_err_q      <= sym_err_d;
    end
  end

  assign pa_det       = pa_det_q;
  assign pa_count     = pa_count_q;
  assign sta_det      = sta_det_q;
  assign sto_det      = sto_det_q;
  assign frame_active = frame_active_q;
  assign sym_valid    = sym_valid_q;
  assign sym_data     = sym_data_q;
  assign sym_err      = sym_err_q;

endmodule

// File: tb/tb_irda_fir_flag_det.sv
// Bench for irda_fir_flag_det: random and directed chip streams compared every
// clock against a chip-history reference model of the flag/symbol rules.
module tb_irda_fir_flag_det;

  localparam int unsigned PA_MIN = 4;

  logic       clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       fir_rx8_enable = 1'b0;
  logic       rx_chip = 1'b0;
  logic       det_enable = 1'b0;
  logic       pa_det, sta_det, sto_det, frame_active, sym_valid, sym_err;
  logic [3:0] pa_count;
  logic [1:0] sym_data;

  irda_fir_flag_det #(.PA_MIN(PA_MIN)) dut (
    .clk(clk), .wb_rst_n(wb_rst_n), .fir_rx8_enable(fir_rx8_enable),
    .rx_chip(rx_chip), .det_enable(det_enable), .pa_det(pa_det),
    .pa_count(pa_count), .sta_det(sta_det), .sto_det(sto_det),
    .frame_active(frame_active), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Flag definitions as lists of chip positions that are 1 (chip 0 oldest).
  int pa_ones [8] = '{0, 8, 10, 12, -1, -1, -1, -1};
  int sta_ones[8] = '{4, 5, 12, 13, 17, 18, 25, 26};
  int sto_ones[8] = '{4, 5, 12, 13, 21, 22, 29, 30};

  function automatic bit is_one(input int ones[8], input int k);
    for (int j = 0; j < 8; j++) if (ones[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: history of the last 32 chips plus spec-level counters.
  bit hist[$];
  int m_state, m_cnt, m_since_pa, m_since_sta;
  bit m_fa;
  bit e_pa, e_sta, e_sto, e_sv, e_se;
  int e_sd;

  function automatic bit flag_match(input int span, input int ones[8]);
    int base;
    if (hist.size() < span) return 1'b0;
    base = hist.size() - span;
    for (int k = 0; k < span; k++)
      if (hist[base + k] != is_one(ones, k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_state = 0; m_cnt = 0; m_since_pa = 0; m_since_sta = 0; m_fa = 1'b0;
    e_pa = 0; e_sta = 0; e_sto = 0; e_sv = 0; e_se = 0; e_sd = 0;
  endtask

  task automatic model_step(input bit strobe, input bit chip, input bit en);
    bit pa_m, sta_m, sto_m;
    int ones_n, pos;
    e_pa = 0; e_sta = 0; e_sto = 0; e_sv = 0; e_se = 0; e_sd = 0;
    if (strobe) begin
      hist.push_back(chip);
      if (hist.size() > 32) hist.delete(0);
    end
    pa_m  = flag_match(16, pa_ones);
    sta_m = flag_match(32, sta_ones);
    sto_m = flag_match(32, sto_ones);
    if (!en) begin
      m_state = 0; m_cnt = 0; m_fa = 0; m_since_pa = 0; m_since_sta = 0;
    end else if (strobe) begin
      case (m_state)
        0: if (pa_m) begin m_state = 1; m_cnt = 1; e_pa = 1; m_since_pa = 0; end
        1: begin
          m_since_pa++;
          if (sta_m && m_cnt >= int'(PA_MIN)) begin
            m_state = 2; e_sta = 1; m_fa = 1; m_cnt = 0; m_since_sta = 0;
          end else if (pa_m) begin
            e_pa = 1; m_since_pa = 0;
            if (m_cnt < 15) m_cnt++;
          end else if (m_since_pa >= 33) begin
            m_state = 0; m_cnt = 0;
          end
        end
        default: begin
          m_since_sta++;
          if (sto_m) begin
            e_sto = 1; m_fa = 0; m_state = 0;
          end else if (m_since_sta >= 32 && (m_since_sta - 32) % 4 == 0) begin
            e_sv = 1; ones_n = 0; pos = 0;
            for (int i = 0; i < 4; i++) if (hist[i]) begin ones_n++; pos = i; end
            if (ones_n == 1) e_sd = pos; else e_se = 1;
          end
        end
      endcase
    end
  endtask

  // Observed-output tallies used by the scenario checks.
  int t_pa, t_sta, t_sto, t_sv, t_se, t_peak, t_fa_err;
  int obs_sym[$];

  task automatic tally_clear();
    t_pa = 0; t_sta = 0; t_sto = 0; t_sv = 0; t_se = 0; t_peak = 0; t_fa_err = 0;
    obs_sym.delete();
  endtask

  task automatic cycle(input bit strobe, input bit chip);
    @(negedge clk);
    fir_rx8_enable = strobe;
    rx_chip = chip;
    @(posedge clk);
    if (!wb_rst_n) model_reset();
    else model_step(strobe, chip, det_enable);
    #1;
    check("pa_det", pa_det, e_pa);
    check("pa_count", pa_count, m_cnt);
    check("sta_det", sta_det, e_sta);
    check("sto_det", sto_det, e_sto);
    check("frame_active", frame_active, m_fa);
    check("sym_valid", sym_valid, e_sv);
    if (e_sv) begin
      check("sym_data", sym_data, e_sd);
      check("sym_err", sym_err, e_se);
    end
    if (pa_det) t_pa++;
    if (sta_det) t_sta++;
    if (sto_det) t_sto++;
    if (int'(pa_count) > t_peak) t_peak = pa_count;
    if (sym_valid) begin
      t_sv++;
      obs_sym.push_back({sym_err, sym_data});
      if (sym_err) begin t_se++; if (frame_active) t_fa_err++; end
    end
  endtask

  int  spacing = 1;    // 1: strobe every clk, 3: every 3rd clk, 0: random
  bit  rand_en = 1'b0;
  logic [3:0] tx_nibs[$];

  task automatic send_chip(input bit c);
    int idle;
    idle = (spacing == 0) ? int'($urandom_range(0, 3)) : spacing - 1;
    if (rand_en && $urandom_range(0, 299) == 0) begin
      det_enable = 1'b0;
      repeat (2) cycle(1'b0, 1'b0);
      det_enable = 1'b1;
    end
    repeat (idle) cycle(1'b0, 1'($urandom));
    cycle(1'b1, c);
  endtask

  task automatic send_flag(input int span, input int ones[8]);
    for (int k = 0; k < span; k++) send_chip(is_one(ones, k));
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int i = 3; i >= 0; i--) send_chip(n[i]);
  endtask

  task automatic send_zeros(input int n);
    repeat (n) send_chip(1'b0);
  endtask

  task automatic send_frame(input int npa);
    repeat (npa) send_flag(16, pa_ones);
    send_flag(32, sta_ones);
    foreach (tx_nibs[i]) send_nib(tx_nibs[i]);
    send_flag(32, sto_ones);
  endtask

  task automatic scenario_basic(input string p);
    int exp8[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    tally_clear();
    tx_nibs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    send_frame(16);
    send_zeros(8);
    check({p, "_pa_det_n"}, t_pa, 16);
    check({p, "_pa_peak"}, t_peak, 15);
    check({p, "_sta_n"}, t_sta, 1);
    check({p, "_sto_n"}, t_sto, 1);
    check({p, "_sym_n"}, t_sv, 8);
    check({p, "_err_n"}, t_se, 0);
    check({p, "_fa_after"}, frame_active, 0);
    for (int i = 0; i < 8; i++)
      check({p, "_sym_seq"}, (i < obs_sym.size()) ? obs_sym[i] : 99, exp8[i]);
  endtask

  task automatic async_reset_mid();
    @(negedge clk);
    fir_rx8_enable = 1'b0;
    #2;
    check("s38_fa_pre", frame_active, 1);
    wb_rst_n = 1'b0;
    #1;
    model_reset();
    check("s38_rst_fa", frame_active, 0);
    check("s38_rst_cnt", pa_count, 0);
    check("s38_rst_pulses", {pa_det, sta_det, sto_det, sym_valid, sym_err}, 0);
    check("s38_rst_data", sym_data, 0);
  endtask

  initial begin
    model_reset();
    tally_clear();
    repeat (3) cycle(1'b0, 1'b0);
    wb_rst_n = 1'b1;
    det_enable = 1'b1;
    repeat (2) cycle(1'b0, 1'b0);

    spacing = 1;
    scenario_basic("s34");

    spacing = 3;
    scenario_basic("s39");

    // Too-short preamble: STA ignored, timeout on the 33rd strobe after last PA.
    spacing = 1;
    tally_clear();
    repeat (3) send_flag(16, pa_ones);
    send_flag(32, sta_ones);
    check("s35_cnt_at_32", pa_count, 3);
    send_chip(1'b0);
    check("s35_cnt_at_33", pa_count, 0);
    check("s35_sta_n", t_sta, 0);
    check("s35_pa_n", t_pa, 3);
    check("s35_fa", frame_active, 0);
    send_zeros(8);

    // Exactly PA_MIN flags, with a non-one-hot symbol in the frame.
    tally_clear();
    tx_nibs = '{4'b1000, 4'b0010, 4'b1100, 4'b0001};
    send_frame(PA_MIN);
    send_zeros(8);
    check("s36_sta_n", t_sta, 1);
    check("s36_sym_n", t_sv, 4);
    check("s36_err_n", t_se, 1);
    check("s36_err_sym", (obs_sym.size() > 2) ? obs_sym[2] : 99, 4);
    check("s36_fa_on_err", t_fa_err, 1);
    check("s36_sto_n", t_sto, 1);

    // det_enable dropped mid-frame, then a full frame after re-enable.
    tally_clear();
    repeat (5) send_flag(16, pa_ones);
    send_flag(32, sta_ones);
    send_nib(4'b1000); send_nib(4'b0100); send_nib(4'b0010);
    check("s37_fa_before", frame_active, 1);
    det_enable = 1'b0;
    cycle(1'b0, 1'b0);
    check("s37_fa_drop", frame_active, 0);
    tally_clear();
    repeat (9) send_nib(4'b0100);
    send_flag(32, sto_ones);
    send_zeros(4);
    check("s37_sym_off", t_sv, 0);
    check("s37_sto_off", t_sto, 0);
    det_enable = 1'b1;
    tally_clear();
    tx_nibs = '{4'b0001, 4'b1000, 4'b0100};
    send_frame(6);
    send_zeros(8);
    check("s37_sta_n", t_sta, 1);
    check("s37_sto_n", t_sto, 1);
    check("s37_sym_n", t_sv, 3);
    check("s37_sym0", (obs_sym.size() > 0) ? obs_sym[0] : 99, 3);

    // Asynchronous reset between edges in the middle of a frame.
    tally_clear();
    repeat (5) send_flag(16, pa_ones);
    send_flag(32, sta_ones);
    repeat (10) send_nib(4'b0010);
    async_reset_mid();
    repeat (3) cycle(1'b0, 1'b0);
    wb_rst_n = 1'b1;
    tally_clear();
    tx_nibs = '{4'b0001, 4'b0010, 4'b1000};
    send_frame(4);
    send_zeros(8);
    check("s38_sta_n", t_sta, 1);
    check("s38_sto_n", t_sto, 1);
    check("s38_sym_n", t_sv, 3);
    check("s38_sym0", (obs_sym.size() > 0) ? obs_sym[0] : 99, 3);
    check("s38_sym1", (obs_sym.size() > 1) ? obs_sym[1] : 99, 2);
    check("s38_sym2", (obs_sym.size() > 2) ? obs_sym[2] : 99, 0);

    // Randomized frames, spacing and noise; the model checks every clock.
    spacing = 0;
    rand_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int nsym;
      repeat ($urandom_range(0, 20)) send_chip(1'($urandom));
      tx_nibs.delete();
      nsym = $urandom_range(0, 10);
      for (int s = 0; s < nsym; s++) begin
        if ($urandom_range(0, 7) == 0) tx_nibs.push_back(4'($urandom_range(1, 15)));
        else tx_nibs.push_back(4'b1000 >> $urandom_range(0, 3));
      end
      send_frame($urandom_range(1, 8));
      send_zeros(6);
    end
    rand_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
